// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN layer controllers.
package snn_pkg;

  localparam int unsigned WL_STATE_W = 3;

  typedef logic [WL_STATE_W-1:0] wl_state_t;

  localparam wl_state_t WL_IDLE  = 3'd0;
  localparam wl_state_t WL_LOAD  = 3'd1;
  localparam wl_state_t WL_RB    = 3'd2;
  localparam wl_state_t WL_DRAIN = 3'd3;
  localparam wl_state_t WL_CHECK = 3'd4;

  // Counter width for a bound n, never narrower than one bit.
  function automatic int unsigned CNT_W(input int unsigned n);
    if (n <= 32'd1) return 32'd1;
    return 32'($clog2(n));
  endfunction

endpackage

// File: rtl/if_layer_weight_loader.sv
// Loads a layer's neuron weight memories from a host stream, holding the
// neurons in reset, then optionally reads every weight back against a checksum.
module if_layer_weight_loader
  import snn_pkg::*;
#(
  parameter int unsigned NUM_NEURONS       = 4,
  parameter int unsigned NUM_INPUTS        = 4,
  parameter int unsigned WEIGHT_SIZE       = 32,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 8,
  parameter int unsigned VERIFY            = 1
) (
  input  logic                               mem_clk,
  input  logic                               rst,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [WEIGHT_SIZE-1:0]             checksum,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [WEIGHT_SIZE-1:0]             s_data,
  output logic                               nrn_rst,
  output logic [WEIGHT_ADDR_WIDTH-1:0]       mem_addr,
  output logic [WEIGHT_SIZE-1:0]             mem_din,
  output logic [NUM_NEURONS-1:0]             mem_wen,
  input  logic [NUM_NEURONS*WEIGHT_SIZE-1:0] mem_dout_bus
);

  localparam int unsigned NW = CNT_W(NUM_NEURONS);
  localparam int unsigned IW = CNT_W(NUM_INPUTS);

  wl_state_t                    r_state;
  logic [NW-1:0]                r_nrn;
  logic [IW-1:0]                r_inp;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_error;
  logic                         r_s_ready;
  logic                         r_nrn_rst;
  logic [WEIGHT_SIZE-1:0]       r_checksum;
  logic [WEIGHT_SIZE-1:0]       r_rb_sum;
  logic [WEIGHT_ADDR_WIDTH-1:0] r_mem_addr;
  logic [WEIGHT_SIZE-1:0]       r_mem_din;
  logic [NUM_NEURONS-1:0]       r_mem_wen;
  logic                         r_rd_vld;
  logic [NW-1:0]                r_rd_nrn;
  logic                         r_sel_vld;
  logic [NW-1:0]                r_sel_nrn;

  wl_state_t                    w_state_nxt;
  logic [NW-1:0]                w_nrn_nxt;
  logic [IW-1:0]                w_inp_nxt;
  logic                         w_done_nxt;
  logic                         w_error_nxt;
  logic [WEIGHT_SIZE-1:0]       w_checksum_nxt;
  logic [WEIGHT_SIZE-1:0]       w_rb_sum_nxt;
  logic [WEIGHT_ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic [WEIGHT_SIZE-1:0]       w_mem_din_nxt;
  logic [NUM_NEURONS-1:0]       w_mem_wen_nxt;
  logic                         w_rd_vld_nxt;
  logic [NW-1:0]                w_rd_nrn_nxt;

  logic                         w_hs;
  logic                         w_inp_last;
  logic                         w_last;
  logic [NW-1:0]                w_nrn_adv;
  logic [IW-1:0]                w_inp_adv;
  logic [NUM_NEURONS-1:0]       w_onehot;
  logic [WEIGHT_SIZE-1:0]       w_rd_word;
  logic [WEIGHT_SIZE-1:0]       w_rb_sum;

  assign w_hs       = r_s_ready && s_valid;
  assign w_inp_last = (r_inp == IW'(NUM_INPUTS - 1));
  assign w_last     = w_inp_last && (r_nrn == NW'(NUM_NEURONS - 1));
  assign w_inp_adv  = w_inp_last ? '0 : r_inp + IW'(1);
  assign w_nrn_adv  = w_last ? '0 : (w_inp_last ? r_nrn + NW'(1) : r_nrn);

  // Write-enable decode for the current neuron and readback slice select.
  always_comb begin
    w_onehot  = '0;
    w_rd_word = '0;
    for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
      w_onehot[n] = (r_nrn == NW'(n));
      if (r_sel_nrn == NW'(n)) w_rd_word = mem_dout_bus[n*WEIGHT_SIZE +: WEIGHT_SIZE];
    end
  end

  // Readback sum including the slice being captured this cycle.
  assign w_rb_sum = r_rb_sum + (r_sel_vld ? w_rd_word : '0);

  always_comb begin
    w_state_nxt    = r_state;
    w_nrn_nxt      = r_nrn;
    w_inp_nxt      = r_inp;
    w_done_nxt     = 1'b0;
    w_error_nxt    = r_error;
    w_checksum_nxt = r_checksum;
    w_rb_sum_nxt   = w_rb_sum;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_din_nxt  = r_mem_din;
    w_mem_wen_nxt  = '0;
    w_rd_vld_nxt   = 1'b0;
    w_rd_nrn_nxt   = r_rd_nrn;

    case (r_state)
      WL_IDLE: begin
        if (start) begin
          w_state_nxt    = WL_LOAD;
          w_nrn_nxt      = '0;
          w_inp_nxt      = '0;
          w_checksum_nxt = '0;
          w_error_nxt    = 1'b0;
          w_rb_sum_nxt   = '0;
        end
      end
      WL_LOAD: begin
        if (w_hs) begin
          w_mem_addr_nxt = WEIGHT_ADDR_WIDTH'(r_inp);
          w_mem_din_nxt  = s_data;
          w_mem_wen_nxt  = w_onehot;
          w_checksum_nxt = r_checksum + s_data;
          w_nrn_nxt      = w_nrn_adv;
          w_inp_nxt      = w_inp_adv;
          if (w_last) begin
            if (VERIFY != 0) begin
              w_state_nxt = WL_RB;
            end else begin
              w_state_nxt = WL_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
      end
      WL_RB: begin
        w_mem_addr_nxt = WEIGHT_ADDR_WIDTH'(r_inp);
        w_rd_vld_nxt   = 1'b1;
        w_rd_nrn_nxt   = r_nrn;
        w_nrn_nxt      = w_nrn_adv;
        w_inp_nxt      = w_inp_adv;
        if (w_last) w_state_nxt = WL_DRAIN;
      end
      WL_DRAIN: begin
        w_state_nxt = WL_CHECK;
      end
      WL_CHECK: begin
        w_error_nxt = (w_rb_sum != r_checksum);
        w_done_nxt  = 1'b1;
        w_state_nxt = WL_IDLE;
      end
      default: begin
        w_state_nxt = WL_IDLE;
      end
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      r_state    <= WL_IDLE;
      r_nrn      <= '0;
      r_inp      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_s_ready  <= 1'b0;
      r_nrn_rst  <= 1'b0;
      r_checksum <= '0;
      r_rb_sum   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_wen  <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_nrn   <= '0;
      r_sel_vld  <= 1'b0;
      r_sel_nrn  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_nrn      <= w_nrn_nxt;
      r_inp      <= w_inp_nxt;
      r_busy     <= (w_state_nxt != WL_IDLE);
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_s_ready  <= (w_state_nxt == WL_LOAD);
      r_nrn_rst  <= (w_state_nxt != WL_IDLE);
      r_checksum <= w_checksum_nxt;
      r_rb_sum   <= w_rb_sum_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_din  <= w_mem_din_nxt;
      r_mem_wen  <= w_mem_wen_nxt;
      r_rd_vld   <= w_rd_vld_nxt;
      r_rd_nrn   <= w_rd_nrn_nxt;
      // Neuron dout lags the issued address by one cycle.
      r_sel_vld  <= r_rd_vld;
      r_sel_nrn  <= r_rd_nrn;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;
  assign checksum = r_checksum;
  assign s_ready  = r_s_ready;
  assign nrn_rst  = r_nrn_rst;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_wen  = r_mem_wen;

endmodule

// File: tb/tb_if_layer_weight_loader.sv
// Directed bench for the weight loader: two instances (VERIFY=1 and VERIFY=0)
// share one stimulus stream; a small neuron memory model answers readback.
module tb_if_layer_weight_loader;

  localparam int unsigned N  = 2;
  localparam int unsigned I  = 4;
  localparam int unsigned WS = 32;
  localparam int unsigned WA = 8;

  logic          clk = 1'b0;
  logic          rst, start, s_valid;
  logic [WS-1:0] s_data;

  logic          busy, done, error, s_ready, nrn_rst;
  logic [WS-1:0] checksum, mem_din;
  logic [WA-1:0] mem_addr;
  logic [N-1:0]  mem_wen;
  logic [N*WS-1:0] mem_dout_bus;

  logic          busy_nv, done_nv, error_nv, s_ready_nv, nrn_rst_nv;
  logic [WS-1:0] checksum_nv, mem_din_nv;
  logic [WA-1:0] mem_addr_nv;
  logic [N-1:0]  mem_wen_nv;

  always #5 clk = ~clk;

  if_layer_weight_loader #(.NUM_NEURONS(N), .NUM_INPUTS(I), .WEIGHT_SIZE(WS),
                           .WEIGHT_ADDR_WIDTH(WA), .VERIFY(1)) u_dut (
    .mem_clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .error(error), .checksum(checksum), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .nrn_rst(nrn_rst), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_wen(mem_wen), .mem_dout_bus(mem_dout_bus));

  if_layer_weight_loader #(.NUM_NEURONS(N), .NUM_INPUTS(I), .WEIGHT_SIZE(WS),
                           .WEIGHT_ADDR_WIDTH(WA), .VERIFY(0)) u_dut_nv (
    .mem_clk(clk), .rst(rst), .start(start), .busy(busy_nv), .done(done_nv),
    .error(error_nv), .checksum(checksum_nv), .s_valid(s_valid),
    .s_ready(s_ready_nv), .s_data(s_data), .nrn_rst(nrn_rst_nv),
    .mem_addr(mem_addr_nv), .mem_din(mem_din_nv), .mem_wen(mem_wen_nv),
    .mem_dout_bus('0));

  // Neuron memory model with registered read and optional bit-0 corruption.
  logic [WS-1:0] nmem [N][I];
  logic [WS-1:0] ndout [N];
  bit            corrupt;
  bit            hs_q;

  always @(posedge clk) begin
    hs_q <= s_valid && s_ready;
    for (int n = 0; n < N; n++) begin
      if (mem_wen[n]) nmem[n][mem_addr[1:0]] <= mem_din;
      ndout[n] <= nmem[n][mem_addr[1:0]] ^
                  ((corrupt && n == 1 && mem_addr == 8'd2) ? 32'd1 : 32'd0);
    end
  end
  assign mem_dout_bus = {ndout[1], ndout[0]};

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int  wlog[$];
  int  bad_wen, done_hi, nv_done_hi, nv_wen, nv_addr_chg;
  bit  err_at_done;

  // Starts a load, feeds beats 1..8 and observes both instances for 40 cycles.
  // Cycle index k counts clock edges after the edge that samples start.
  task automatic run_load(input bit stall, input bit restart,
                          output int done_cyc, output int nv_cyc, output int last_acc);
    int          beat;
    bit          acc;
    logic [7:0]  nv_addr_prev;
    beat = 0;
    wlog.delete();
    bad_wen = 0; done_hi = 0; nv_done_hi = 0; nv_wen = 0; nv_addr_chg = 0;
    err_at_done = 1'b0;
    done_cyc = -1; nv_cyc = -1; last_acc = -1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("start_busy",    32'(busy),    32'd1);
    check("start_s_ready", 32'(s_ready), 32'd1);
    check("start_nrn_rst", 32'(nrn_rst), 32'd1);
    check("start_err_clr", 32'(error),   32'd0);
    nv_addr_prev = mem_addr_nv;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        done_hi++;
        if (done_cyc < 0) begin done_cyc = k; err_at_done = error; end
      end
      if (done_nv) begin
        nv_done_hi++;
        if (nv_cyc < 0) nv_cyc = k;
      end
      if (|mem_wen) begin
        wlog.push_back({6'd0, mem_wen, mem_addr, mem_din[15:0]});
        if (!hs_q) bad_wen++;
      end
      if (|mem_wen_nv) nv_wen++;
      if (nv_cyc >= 0 && k > nv_cyc && mem_addr_nv != nv_addr_prev) nv_addr_chg++;
      nv_addr_prev = mem_addr_nv;
      start   = restart && (k == 3);
      s_valid = (beat < 8) && (!stall || (k % 2 == 0));
      s_data  = 32'(beat + 1);
      acc     = s_valid && s_ready;
      @(negedge clk);
      if (acc) begin
        beat++;
        last_acc = k + 1;
      end
    end
    s_valid = 1'b0;
    start   = 1'b0;
  endtask

  // Neuron-major write order: beat b -> neuron b/4, address b%4, data b+1.
  task automatic check_writes(input string tag);
    logic [31:0] got;
    logic [31:0] exp;
    check({tag, "_nwrites"}, 32'(wlog.size()), 32'd8);
    for (int b = 0; b < 8; b++) begin
      got = (b < wlog.size()) ? 32'(wlog[b]) : 32'hffff_ffff;
      exp = {6'd0, (b < 4) ? 2'b01 : 2'b10, 8'(b % 4), 16'(b + 1)};
      check($sformatf("%s_wr%0d", tag, b), got, exp);
    end
  endtask

  int dc, nc, la, done_after_rst;

  initial begin
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check("rst_error",    32'(error),    32'd0);
    check("rst_s_ready",  32'(s_ready),  32'd0);
    check("rst_nrn_rst",  32'(nrn_rst),  32'd0);
    check("rst_mem_wen",  32'(mem_wen),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din",  mem_din,       32'd0);
    check("rst_checksum", checksum,      32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic load, no stalls: done 18 edges after the start edge.
    run_load(1'b0, 1'b0, dc, nc, la);
    check_writes("basic");
    check("basic_last_acc",   32'(la),          32'd8);
    check("basic_done_lat",   32'(dc),          32'd18);
    check("basic_done_width", 32'(done_hi),     32'd1);
    check("basic_checksum",   checksum,         32'd36);
    check("basic_error",      32'(err_at_done), 32'd0);
    check("basic_busy_end",   32'(busy),        32'd0);
    check("basic_nrn_rst_end", 32'(nrn_rst),    32'd0);
    check("basic_bad_wen",    32'(bad_wen),     32'd0);
    check("nv_done_lat",      32'(nc),          32'd8);
    check("nv_done_width",    32'(nv_done_hi),  32'd1);
    check("nv_writes",        32'(nv_wen),      32'd8);
    check("nv_no_rb_addr",    32'(nv_addr_chg), 32'd0);
    check("nv_checksum",      checksum_nv,      32'd36);

    // Stream valid on alternate cycles.
    run_load(1'b1, 1'b0, dc, nc, la);
    check_writes("stall");
    check("stall_last_acc", 32'(la),          32'd15);
    check("stall_done_lat", 32'(dc),          32'd25);
    check("stall_bad_wen",  32'(bad_wen),     32'd0);
    check("stall_checksum", checksum,         32'd36);
    check("stall_error",    32'(err_at_done), 32'd0);
    check("stall_nv_done",  32'(nc),          32'd15);
    check("stall_nv_rb",    32'(nv_addr_chg), 32'd0);

    // Readback of neuron 1 address 2 corrupted in bit 0.
    corrupt = 1'b1;
    run_load(1'b0, 1'b0, dc, nc, la);
    check("corrupt_done_lat", 32'(dc),          32'd18);
    check("corrupt_error",    32'(err_at_done), 32'd1);
    check("corrupt_sticky",   32'(error),       32'd1);
    check("corrupt_checksum", checksum,         32'd36);
    corrupt = 1'b0;

    // start pulsed mid-LOAD is ignored; error cleared by this start.
    run_load(1'b0, 1'b1, dc, nc, la);
    check_writes("restart");
    check("restart_done_lat", 32'(dc),          32'd18);
    check("restart_done_w",   32'(done_hi),     32'd1);
    check("restart_checksum", checksum,         32'd36);
    check("restart_error",    32'(err_at_done), 32'd0);

    // Reset after three accepted beats.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; s_valid = 1'b1;
    for (int b = 0; b < 3; b++) begin
      s_data = 32'(b + 1);
      @(negedge clk);
    end
    check("pre_rst_wen", 32'(mem_wen), 32'd1);
    rst = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    check("midrst_s_ready",  32'(s_ready),  32'd0);
    check("midrst_mem_wen",  32'(mem_wen),  32'd0);
    check("midrst_nrn_rst",  32'(nrn_rst),  32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    check("midrst_checksum", checksum,      32'd0);
    check("midrst_nv_busy",  32'(busy_nv),  32'd0);
    rst = 1'b0;
    done_after_rst = 0;
    for (int k = 0; k < 30; k++) begin
      if (done || done_nv) done_after_rst++;
      @(negedge clk);
    end
    check("midrst_no_done", 32'(done_after_rst), 32'd0);
    check("midrst_idle",    32'(busy),           32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
